// File: rtl/proc_pkg.sv
// Shared definitions for the fetch stage and the processor it feeds:
// instruction width, opcode values, the NOP word and FSM state codes.
package proc_pkg;

    localparam int INSTR_W = 8;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_INC  = 4'h1;
    localparam logic [3:0] OP_DEC  = 4'h2;
    localparam logic [3:0] OP_SHL  = 4'h3;
    localparam logic [3:0] OP_SHR  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [INSTR_W-1:0] NOP_WORD = 8'h00;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // An issued word counts toward issued_cnt unless it is a NOP or HALT.
    function automatic logic op_counts(input logic [3:0] op);
        return (op != OP_NOP) && (op != OP_HALT);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Program-load, control and issue signals between the fetch unit and its
// controller / downstream processor.
interface instr_fetch_unit_if #(parameter int AW = 4);
    import proc_pkg::*;

    logic               load_en;
    logic [AW-1:0]      load_addr;
    logic [INSTR_W-1:0] load_data;
    logic               start;
    logic               stall;
    logic [INSTR_W-1:0] instr_out;
    logic [AW-1:0]      pc_out;
    logic               busy;
    logic               done;
    logic [AW:0]        issued_cnt;

    modport master (
        output load_en, load_addr, load_data, start, stall,
        input  instr_out, pc_out, busy, done, issued_cnt
    );

    modport slave (
        input  load_en, load_addr, load_data, start, stall,
        output instr_out, pc_out, busy, done, issued_cnt
    );

endinterface

// File: rtl/instr_mem.sv
// Program memory: DEPTH x INSTR_W words, synchronous write, combinational
// read, cleared to NOP by reset.
module instr_mem
    import proc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem_reg [DEPTH];

    // Reset must clear every word, so this stays a register array
    // rather than a block RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= NOP_WORD;
            end
        end else if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/issue stage: after start, issues one program word per clock until a
// HALT opcode or the last address, inserting NOPs while stalled.
module instr_fetch_unit
    import proc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    instr_fetch_unit_if.slave bus
);

    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_MAX = {(AW + 1){1'b1}};

    logic [1:0]         state_reg, state_next;
    logic [AW-1:0]      pc_reg, pc_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic [AW:0]        cnt_reg, cnt_next;

    logic               mem_we;
    logic [INSTR_W-1:0] fetch_word;
    logic [3:0]         fetch_op;

    // Loads are only honoured while no program is executing.
    assign mem_we = bus.load_en && (state_reg != ST_RUN);

    instr_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (bus.load_addr),
        .wdata (bus.load_data),
        .raddr (pc_reg),
        .rdata (fetch_word)
    );

    assign fetch_op = fetch_word[INSTR_W-1 -: 4];

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = NOP_WORD;
        cnt_next   = cnt_reg;

        case (state_reg)
            ST_RUN: begin
                if (!bus.stall) begin
                    if (fetch_op == OP_HALT) begin
                        state_next = ST_DONE;
                    end else begin
                        instr_next = fetch_word;
                        if (op_counts(fetch_op) && (cnt_reg != CNT_MAX)) begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                        // The last word is issued but pc stays put; no wrap.
                        if (pc_reg == PC_LAST) begin
                            state_next = ST_DONE;
                        end else begin
                            pc_next = pc_reg + 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    state_next = ST_RUN;
                    pc_next    = '0;
                    cnt_next   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            instr_reg <= NOP_WORD;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.instr_out  = instr_reg;
    assign bus.pc_out     = pc_reg;
    assign bus.busy       = (state_reg == ST_RUN);
    assign bus.done       = (state_reg == ST_DONE);
    assign bus.issued_cnt = cnt_reg;

endmodule
